// File: rtl/addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one external adder-subtractor between NREQ requesters.
// Define ADDSUB_OVF_EN to add the registered signed-overflow flag rsp_ovf.
//
// state | meaning
// IDLE  | waiting for a request; grant latched into as_* on the edge leaving IDLE
// EXEC  | adder output settled; result captured into rsp_s at the edge
// DONE  | one-hot done pulse to the served requester for this one cycle
module addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_sel,
  input  logic [W*NREQ-1:0]  req_a,
  input  logic [W*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]    done,
  output logic [W-1:0]       rsp_s,
  output logic               busy,
  output logic [IW-1:0]      gnt_idx,
  output logic [W-1:0]       as_a,
  output logic [W-1:0]       as_b,
  output logic               as_sel,
  input  logic [W-1:0]       as_s
`ifdef ADDSUB_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts just after the last winner, so a requester holding req
  // high yields to everyone else that is waiting.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= '0;
      rsp_s   <= '0;
      gnt_idx <= '0;
      last    <= IW'(NREQ - 1);
      as_a    <= '0;
      as_b    <= '0;
      as_sel  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      rsp_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx <= winner;
            last    <= winner;
            as_a    <= req_a[winner * W +: W];
            as_b    <= req_b[winner * W +: W];
            as_sel  <= req_sel[winner];
          end
        end
        EXEC: begin
          rsp_s <= as_s;
          done  <= NREQ'(1) << gnt_idx;
`ifdef ADDSUB_OVF_EN
          // Subtraction overflows when the operand signs differ, addition when they match.
          rsp_ovf <= ((as_a[W-1] ^ as_b[W-1]) == as_sel) && (as_s[W-1] != as_a[W-1]);
`endif
        end
        DONE:    done <= '0;
        default: done <= '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: models the external adder and scores
// every done pulse against a queue of expected results.
module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_sel = '0;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      rsp_s;
  logic              busy;
  logic [IW-1:0]     gnt_idx;
  logic [W-1:0]      as_a, as_b, as_s;
  logic              as_sel;
`ifdef ADDSUB_OVF_EN
  logic              rsp_ovf;
`endif

  always #5 clk = ~clk;

  // External adder-subtractor
  assign as_s = as_sel ? (as_a - as_b) : (as_a + as_b);

  addsub_arbiter #(.NREQ(NREQ), .W(W), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .done(done), .rsp_s(rsp_s),
    .busy(busy), .gnt_idx(gnt_idx), .as_a(as_a), .as_b(as_b),
    .as_sel(as_sel), .as_s(as_s)
`ifdef ADDSUB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] s;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   done_cycs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -1;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] model_s(input logic [31:0] a, input logic [31:0] b, input logic sel);
    return sel ? a - b : a + b;
  endfunction

  function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b, input logic sel);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sel ? sa - sb : sa + sb;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_cycs.push_back(cyc);
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=%b, expected no done", done);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (done !== (4'b0001 << e.idx)) begin
            errors++;
            $display("FAIL done_onehot: got %b, expected %b", done, 4'b0001 << e.idx);
          end
          checks++;
          if (rsp_s !== e.s) begin
            errors++;
            $display("FAIL rsp_s req%0d: got %h, expected %h", e.idx, rsp_s, e.s);
          end
          checks++;
          if (gnt_idx !== IW'(e.idx)) begin
            errors++;
            $display("FAIL gnt_idx: got %0d, expected %0d", gnt_idx, e.idx);
          end
`ifdef ADDSUB_OVF_EN
          checks++;
          if (rsp_ovf !== e.ovf) begin
            errors++;
            $display("FAIL rsp_ovf req%0d: got %b, expected %b", e.idx, rsp_ovf, e.ovf);
          end
`endif
        end
      end
    end
  endtask

  // Drives one request in an IDLE cycle and queues its expected result.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [31:0] s, input logic ovf, output int c);
    exp_t e;
    @(negedge clk);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_sel[idx] = sel;
    req[idx] = 1'b1;
    e.idx = idx;
    e.s = s;
    e.ovf = ovf;
    sbq.push_back(e);
    c = cyc;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int c, n;
    reset_dut();
    #1;
    checks++;
    if ({done, rsp_s, as_a, as_b, as_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b rsp_s=%h as_a=%h as_b=%h as_sel=%b, expected all 0",
               done, rsp_s, as_a, as_b, as_sel);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (gnt_idx !== '0) begin errors++; $display("FAIL reset_gnt_idx: got %0d, expected 0", gnt_idx); end

    issue(0, 32'd10, 32'd3, 1'b0, 32'd13, 1'b0, c);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL exec_busy: got %b, expected 1", busy); end
    rst = 1'b1;
    req = '0;
    sbq.delete();
    n = done_cnt;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%b done=%b, expected busy=0 done=0", busy, done);
    end
    checks++;
    if (as_a !== '0) begin errors++; $display("FAIL midop_reset_as_a: got %h, expected 0", as_a); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== n) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses, expected 0", done_cnt - n);
    end
  endtask

  task automatic test_add_sub();
    int c;
    bit ok;
    issue(0, 32'd14093195, 32'd2955, 1'b0, 32'h00D71716, 1'b0, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL add_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    checks++;
    if (last_done_cyc !== c + 2) begin
      errors++;
      $display("FAIL add_latency: got done at cycle %0d, expected %0d", last_done_cyc, c + 2);
    end

    issue(0, 32'd14093195, 32'd2955, 1'b1, 32'h00D70000, 1'b0, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL sub_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    checks++;
    if (last_done_cyc !== c + 2) begin
      errors++;
      $display("FAIL sub_latency: got done at cycle %0d, expected %0d", last_done_cyc, c + 2);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] av[4];
    logic [31:0] bv[4];
    logic        sv[4];
    exp_t        e;
    int          c;
    int          order[5];
    av = '{32'd1000, 32'd50, 32'h40000000, 32'd7};
    bv = '{32'd234, 32'd70, 32'h40000000, 32'd7};
    sv = '{1'b0, 1'b1, 1'b0, 1'b1};
    order = '{0, 1, 2, 3, 0};
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = av[i];
      req_b[i*W +: W] = bv[i];
      req_sel[i] = sv[i];
    end
    req = 4'b1111;
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      e.idx = order[i];
      e.s = model_s(av[order[i]], bv[order[i]], sv[order[i]]);
      e.ovf = model_ovf(av[order[i]], bv[order[i]], sv[order[i]]);
      sbq.push_back(e);
    end
    done_cycs.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_cycs.size() >= 5) break;
    end
    req = '0;
    checks++;
    if (done_cycs.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, expected 5", done_cycs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (done_cycs[i] !== c + 2 + 3 * i) begin
          errors++;
          $display("FAIL rr_spacing grant%0d: got cycle %0d, expected %0d", i, done_cycs[i], c + 2 + 3 * i);
        end
      end
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (done_cycs.size() != 5 || sbq.size() != 0) begin
      errors++;
      $display("FAIL rr_after: got %0d grants and %0d pending, expected 5 and 0", done_cycs.size(), sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_wrap();
    int c;
    bit ok;
    issue(2, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b0, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_add_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end

    issue(1, 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_sub_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rsp_s !== 32'hFFFFFFFF || done !== '0 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL rsp_hold: got rsp_s=%h done=%b gnt_idx=%0d, expected ffffffff 0000 1", rsp_s, done, gnt_idx);
    end
  endtask

  task automatic test_hold_operands();
    int c;
    bit ok;
    issue(3, 32'd100, 32'd58, 1'b1, 32'd42, 1'b0, c);
    @(negedge clk);
    req_a[3*W +: W] = 32'd999;
    req_b[3*W +: W] = 32'd1;
    req_sel[3] = 1'b0;
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    checks++;
    if (last_done_cyc !== c + 2) begin
      errors++;
      $display("FAIL hold_latency: got done at cycle %0d, expected %0d", last_done_cyc, c + 2);
    end
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_ovf();
    int c;
    bit ok;
    issue(1, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b1, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_add_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    issue(2, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_sub_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
    issue(0, 32'd5, 32'd3, 1'b1, 32'd2, 1'b0, c);
    wait_drain(ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_none_timeout: pending %0d, expected 0", sbq.size()); sbq.delete(); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_add_sub();
    test_round_robin();
    test_wrap();
    test_hold_operands();
`ifdef ADDSUB_OVF_EN
    test_ovf();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
